// File: rtl/mdr_sequencer.sv
// Control sequencer for the multiply/divide/square-root datapath: load, iterate, capture, handshake.
// Outputs are flops updated alongside the state, so nothing combinational reaches them from inputs.
module mdr_sequencer #(
    parameter int DW    = 32,  // even, 4..62
    parameter int CNT_W = 6    // 2**CNT_W > DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_ack,
    input  logic             i_clear,
    output logic             o_load,
    output logic             o_shift_en,
    output logic [CNT_W-1:0] o_iter,
    output logic [1:0]       o_op_sel,
    output logic             o_final_flag,
    output logic             o_busy,
    output logic             o_ready,
    output logic             o_error
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FINAL, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(DW - 1);
    localparam logic [CNT_W-1:0] SQ_LAST = CNT_W'(DW / 2 - 1);
    localparam logic [1:0]       OP_SQRT = 2'b10;
    localparam logic [1:0]       OP_ILL  = 2'b11;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_sel;
    logic [CNT_W-1:0] last;

    // Only sqrt runs half-length; the latched op decides, never the live input.
    assign last     = (op_sel == OP_SQRT) ? SQ_LAST : MD_LAST;
    assign o_iter   = cnt;
    assign o_op_sel = op_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_sel       <= 2'b00;
            o_load       <= 1'b0;
            o_shift_en   <= 1'b0;
            o_final_flag <= 1'b0;
            o_busy       <= 1'b0;
            o_ready      <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_load       <= 1'b0;
            o_final_flag <= 1'b0;
            if (i_clear) begin
                state      <= IDLE;
                cnt        <= '0;
                o_shift_en <= 1'b0;
                o_busy     <= 1'b0;
                o_ready    <= 1'b0;
                o_error    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            op_sel <= i_op;
                            cnt    <= '0;
                            if (i_op == OP_ILL) begin
                                state   <= ERR;
                                o_error <= 1'b1;
                            end else begin
                                state  <= LOAD;
                                o_load <= 1'b1;
                                o_busy <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        state      <= RUN;
                        o_shift_en <= 1'b1;
                    end
                    RUN: begin
                        if (cnt == last) begin
                            state        <= FINAL;
                            cnt          <= '0;
                            o_shift_en   <= 1'b0;
                            o_final_flag <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    FINAL: begin
                        state   <= DONE;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end
                    DONE: begin
                        if (i_ack) begin
                            state   <= IDLE;
                            o_ready <= 1'b0;
                        end
                    end
                    ERR: begin
                        if (i_ack) begin
                            state   <= IDLE;
                            o_error <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdr_sequencer.sv
// Directed bench for mdr_sequencer at DW=32: latency, sqrt length, illegal op, clear, back-to-back, async reset.
module tb_mdr_sequencer;

    localparam int DW    = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start, i_ack, i_clear;
    logic [1:0]       i_op;
    logic             o_load, o_shift_en, o_final_flag, o_busy, o_ready, o_error;
    logic [CNT_W-1:0] o_iter;
    logic [1:0]       o_op_sel;
    logic [5:0]       ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // {load, shift_en, final_flag, busy, ready, error}
    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_LOAD  = 6'b100100;
    localparam logic [5:0] C_RUN   = 6'b010100;
    localparam logic [5:0] C_FINAL = 6'b001100;
    localparam logic [5:0] C_DONE  = 6'b000010;
    localparam logic [5:0] C_ERR   = 6'b000001;

    assign ctrl = {o_load, o_shift_en, o_final_flag, o_busy, o_ready, o_error};

    mdr_sequencer #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_ack(i_ack), .i_clear(i_clear),
        .o_load(o_load), .o_shift_en(o_shift_en), .o_iter(o_iter), .o_op_sel(o_op_sel),
        .o_final_flag(o_final_flag), .o_busy(o_busy), .o_ready(o_ready), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; i_start = 1'b0; i_op = 2'b00; i_ack = 1'b0; i_clear = 1'b0;
        step(); step();
        n_checks++;
        if ({ctrl, o_iter, o_op_sel} !== {C_IDLE, 6'd0, 2'b00}) begin
            n_fail++; $display("FAIL reset: ctrl=%b iter=%0d op=%b, want ctrl=%b iter=0 op=00", ctrl, o_iter, o_op_sel, C_IDLE);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL reset_release: ctrl=%b want %b", ctrl, C_IDLE); end
    endtask

    task automatic test_mul();
        i_start = 1'b1; i_op = 2'b00;
        step();
        i_start = 1'b0; i_op = 2'b11;  // late op change must not matter
        n_checks++;
        if (ctrl !== C_LOAD) begin n_fail++; $display("FAIL mul_load: ctrl=%b want %b", ctrl, C_LOAD); end
        for (int k = 0; k < 32; k++) begin
            step();
            n_checks++;
            if (ctrl !== C_RUN || o_iter !== 6'(k)) begin
                n_fail++; $display("FAIL mul_run: k=%0d ctrl=%b iter=%0d want ctrl=%b iter=%0d", k, ctrl, o_iter, C_RUN, k);
            end
        end
        step();
        n_checks++;
        if (ctrl !== C_FINAL || o_iter !== 6'd0) begin n_fail++; $display("FAIL mul_final: ctrl=%b iter=%0d want %b iter=0", ctrl, o_iter, C_FINAL); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (ctrl !== C_DONE || o_op_sel !== 2'b00) begin
                n_fail++; $display("FAIL mul_done_hold: ctrl=%b op=%b want %b op=00", ctrl, o_op_sel, C_DONE);
            end
        end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_checks++;
        if (ctrl !== C_IDLE || o_op_sel !== 2'b00) begin n_fail++; $display("FAIL mul_ack: ctrl=%b op=%b want %b op=00", ctrl, o_op_sel, C_IDLE); end
    endtask

    task automatic test_sqrt();
        int shifts = 0;
        i_start = 1'b1; i_op = 2'b10;
        step();
        i_start = 1'b0; i_op = 2'b00;
        n_checks++;
        if (ctrl !== C_LOAD) begin n_fail++; $display("FAIL sqrt_load: ctrl=%b want %b", ctrl, C_LOAD); end
        // T+2 .. T+17 shift, T+18 final
        for (int k = 2; k <= 18; k++) begin
            step();
            if (o_shift_en) shifts++;
            if (k == 18) begin
                n_checks++;
                if (ctrl !== C_FINAL) begin n_fail++; $display("FAIL sqrt_final: ctrl=%b want %b at T+18", ctrl, C_FINAL); end
            end
        end
        n_checks++;
        if (shifts != 16) begin n_fail++; $display("FAIL sqrt_shift_count: got %0d want 16", shifts); end
        step();
        n_checks++;
        if (ctrl !== C_DONE || o_op_sel !== 2'b10) begin n_fail++; $display("FAIL sqrt_done: ctrl=%b op=%b want %b op=10", ctrl, o_op_sel, C_DONE); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_checks++;
        if (ctrl !== C_IDLE || o_op_sel !== 2'b10) begin n_fail++; $display("FAIL sqrt_ack: ctrl=%b op=%b want %b op=10", ctrl, o_op_sel, C_IDLE); end
    endtask

    task automatic test_illegal();
        i_start = 1'b1; i_op = 2'b11;
        step();
        i_op = 2'b01;  // start stays high: ignored outside IDLE
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ctrl !== C_ERR || o_op_sel !== 2'b11) begin
                n_fail++; $display("FAIL illegal_err: k=%0d ctrl=%b op=%b want %b op=11", k, ctrl, o_op_sel, C_ERR);
            end
            step();
        end
        i_start = 1'b0; i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_checks++;
        if (ctrl !== C_IDLE || o_op_sel !== 2'b11) begin n_fail++; $display("FAIL illegal_ack: ctrl=%b op=%b want %b op=11", ctrl, o_op_sel, C_IDLE); end
    endtask

    task automatic test_clear();
        i_start = 1'b1; i_op = 2'b01;
        step();
        i_start = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            step();
            n_checks++;
            if (ctrl !== C_RUN || o_iter !== 6'(k) || o_op_sel !== 2'b01) begin
                n_fail++; $display("FAIL clear_run: k=%0d ctrl=%b iter=%0d op=%b want %b iter=%0d op=01", k, ctrl, o_iter, o_op_sel, C_RUN, k);
            end
            if (k == 5) begin i_start = 1'b1; i_op = 2'b00; end
            if (k == 6) i_start = 1'b0;
            if (k == 20) i_clear = 1'b1;
        end
        step();
        i_clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (ctrl !== C_IDLE || o_iter !== 6'd0 || o_op_sel !== 2'b01) begin
                n_fail++; $display("FAIL clear_idle: k=%0d ctrl=%b iter=%0d op=%b want %b iter=0 op=01", k, ctrl, o_iter, o_op_sel, C_IDLE);
            end
            step();
        end
        // clear outranks a start in the same cycle
        i_start = 1'b1; i_op = 2'b10; i_clear = 1'b1;
        step();
        i_start = 1'b0; i_clear = 1'b0;
        n_checks++;
        if (ctrl !== C_IDLE || o_op_sel !== 2'b01) begin n_fail++; $display("FAIL clear_vs_start: ctrl=%b op=%b want %b op=01", ctrl, o_op_sel, C_IDLE); end
    endtask

    task automatic test_back_to_back();
        i_start = 1'b1; i_op = 2'b00;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 34; k++) step();
        n_checks++;
        if (ctrl !== C_DONE) begin n_fail++; $display("FAIL b2b_done: ctrl=%b want %b at T+35", ctrl, C_DONE); end
        i_start = 1'b1; i_op = 2'b10; i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_checks++;
        if (ctrl !== C_IDLE || o_op_sel !== 2'b00) begin n_fail++; $display("FAIL b2b_ack_start: ctrl=%b op=%b want %b op=00", ctrl, o_op_sel, C_IDLE); end
        step();
        i_start = 1'b0;
        n_checks++;
        if (ctrl !== C_LOAD || o_op_sel !== 2'b10) begin n_fail++; $display("FAIL b2b_reload: ctrl=%b op=%b want %b op=10", ctrl, o_op_sel, C_LOAD); end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        int finals = 0;
        i_start = 1'b1; i_op = 2'b00;
        step();
        i_start = 1'b0;
        for (int k = 0; k <= 10; k++) step();
        n_checks++;
        if (ctrl !== C_RUN || o_iter !== 6'd10) begin n_fail++; $display("FAIL rstmid_pre: ctrl=%b iter=%0d want %b iter=10", ctrl, o_iter, C_RUN); end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ctrl, o_iter, o_op_sel} !== {C_IDLE, 6'd0, 2'b00}) begin
            n_fail++; $display("FAIL rstmid_async: ctrl=%b iter=%0d op=%b want all zero", ctrl, o_iter, o_op_sel);
        end
        step();
        rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (o_final_flag) finals++;
        end
        n_checks++;
        if (ctrl !== C_IDLE || o_iter !== 6'd0 || finals != 0) begin
            n_fail++; $display("FAIL rstmid_after: ctrl=%b iter=%0d finals=%0d want idle iter=0 finals=0", ctrl, o_iter, finals);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_sqrt();
        test_illegal();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, want completion before 100000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
Central control FSM for the multiply/divide/square-root (MDR) datapath.
- Accepts one operation request at a time and pulses the operand-load strobe.
- Drives the per-iteration shift enable for the required number of cycles.
- Pulses the flag that makes the final-product register capture the result.
- Holds a ready/valid indication until the consumer acknowledges it.

Parameters:
DW, 32, operand/result width in bits; must be even, 4..62
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DW

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
i_start  input  1  operation request; sampled only in IDLE
i_op  input  2  operation: 00 mul, 01 div, 10 sqrt, 11 illegal
i_ack  input  1  consumer acknowledge of result/error
i_clear  input  1  synchronous abort; highest priority after reset
o_load  output  1  one-cycle operand-load strobe to datapath
o_shift_en  output  1  iteration enable, high for every RUN cycle
o_iter  output  CNT_W  current iteration index, 0-based
o_op_sel  output  2  operation latched at start, held until next start
o_final_flag  output  1  one-cycle capture strobe to final-product stage
o_busy  output  1  high in LOAD, RUN, FINAL
o_ready  output  1  result valid, high in DONE
o_error  output  1  illegal-op indication, high in ERR

Behaviour:
- States: IDLE, LOAD, RUN, FINAL, DONE, ERR.
- Moore machine: all outputs decode from state, counter and op flops only. There is no combinational input-to-output path.
- Reset (rst=0, async): state=IDLE, counter=0, op_sel=00. All outputs are 0; o_op_sel=00 and o_iter=0.
- Iteration count N: mul=DW, div=DW, sqrt=DW/2.
- IDLE:
  - i_start=1 and i_op!=11: latch i_op into op_sel, counter=0, go to LOAD.
  - i_start=1 and i_op=11: latch op_sel=11, go to ERR.
  - Otherwise stay in IDLE.
- LOAD: o_load=1 for exactly one cycle, then RUN.
- RUN:
  - o_shift_en=1 and o_iter=counter.
  - Counter increments each cycle.
  - When counter==N-1, the next state is FINAL and the counter resets to 0.
  - RUN lasts exactly N cycles.
- FINAL: o_final_flag=1 for exactly one cycle, then DONE.
- DONE: o_ready=1. Stay until i_ack=1, then IDLE on the next edge.
- ERR: o_error=1. Stay until i_ack=1, then IDLE.
- Latency, with start sampled at edge T:
  - o_load high in cycle T+1.
  - o_shift_en high in T+2..T+N+1.
  - o_final_flag high in T+N+2.
  - o_ready rises in T+N+3.
  - For DW=32 mul, ready is 35 cycles after start.
- Back-to-back: minimum spacing is one IDLE cycle after ack. i_start in the same cycle as i_ack in DONE/ERR is ignored; the requester must re-assert in IDLE.
- i_start asserted outside IDLE is ignored. o_op_sel does not change.
- i_op changes after start are ignored; o_op_sel stays stable through DONE/ERR.
- i_ack outside DONE/ERR is ignored.
- i_clear=1 in any state:
  - Next state is IDLE and counter=0; o_op_sel is retained.
  - No o_final_flag is issued if the clear lands in RUN.
  - i_clear beats i_start and i_ack in the same cycle.
- Async reset mid-operation: immediate return to reset values. No strobe is completed.
- o_busy, o_ready and o_error are mutually exclusive. o_load, o_shift_en and o_final_flag are mutually exclusive.

Test Plan:
- Reset mid-RUN (DW=32, mul), assert rst=0 at iteration 10 → all outputs 0 asynchronously; after release, state is IDLE with o_iter=0 and no o_final_flag.
- Mul, DW=32: pulse i_start with i_op=00 at edge T → o_load at T+1, o_shift_en for 32 cycles (o_iter 0..31), o_final_flag at T+34, o_ready at T+35 and held until i_ack.
- Sqrt, DW=32 (i_op=10) → exactly 16 shift cycles, o_final_flag at T+18, o_op_sel=10 held; ack → IDLE one cycle later.
- Illegal op i_op=11 → ERR next cycle with o_error=1, no o_load/o_shift_en/o_final_flag; stays asserted until i_ack, then IDLE.
- Div started, i_start re-pulsed with i_op=00 at iteration 5, then i_clear=1 at iteration 20 → second start ignored (o_op_sel stays 01); IDLE next cycle, no o_final_flag, o_ready stays 0.
- In DONE, assert i_start and i_ack in the same cycle → IDLE, no new LOAD; re-assert i_start the next cycle → LOAD follows.
